calc_op_sequencer: RTL and testbench

- Keypad-side initiator for the 32-bit calculator ALU.
- Accepts key events and accumulates decimal operands. It issues opcode/operand pairs to the ALU, waits a configurable latency, captures `numC`, and owns the calculator memory register.
- Sits between the key decoder and the combinational ALU; drives the display value.

---
 rtl/calc_op_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_calc_op_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_op_sequencer.sv
// rtl/calc_op_sequencer.sv - keypad-side operand/opcode sequencer for the calculator ALU
// Optional divide-by-zero guard: define CALC_SEQ_DIV0_GUARD_EN.
module calc_op_sequencer #(
  parameter int OPCODE_LENGTH = 5,
  parameter int RESULT_WIDTH  = 32,
  parameter int ALU_LATENCY   = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           key_valid,
  output logic                           key_ready,
  input  logic [1:0]                     key_type,
  input  logic [OPCODE_LENGTH-1:0]       key_data,
  output logic [OPCODE_LENGTH-1:0]       alu_opcode,
  output logic signed [RESULT_WIDTH-1:0] alu_num_a,
  output logic signed [RESULT_WIDTH-1:0] alu_num_b,
  output logic                           alu_req,
  input  logic signed [RESULT_WIDTH-1:0] alu_result,
  output logic signed [RESULT_WIDTH-1:0] disp_value,
  output logic                           done,
  output logic                           err,
  output logic signed [RESULT_WIDTH-1:0] mem_value
);
  typedef logic [OPCODE_LENGTH-1:0] op_t;
  localparam op_t OP_ADD  = op_t'(0);
  localparam op_t OP_SUB  = op_t'(1);
  localparam op_t OP_MUL  = op_t'(2);
  localparam op_t OP_DIV  = op_t'(3);
  localparam op_t OP_MOD  = op_t'(11);
  localparam op_t OP_MADD = op_t'(17);
  localparam op_t OP_MSUB = op_t'(18);
  localparam op_t OP_MR   = op_t'(20);
  localparam op_t OP_MC   = op_t'(24);

  localparam logic [1:0] K_DIGIT = 2'd0;
  localparam logic [1:0] K_OP    = 2'd1;
  localparam logic [1:0] K_EQ    = 2'd2;

  localparam int AW = RESULT_WIDTH + 5;
  localparam logic [AW-1:0] VMAX = {6'b0, {(RESULT_WIDTH-1){1'b1}}};

`ifdef CALC_SEQ_DIV0_GUARD_EN
  localparam bit DIV_GUARD = 1'b1;
`else
  localparam bit DIV_GUARD = 1'b0;
`endif

  typedef enum logic [1:0] {S_ENTRY_A, S_ENTRY_B, S_EXEC, S_SHOW} state_t;

  state_t                  state;
  logic signed [RESULT_WIDTH-1:0] a, b, eff_b, iss_a, iss_b;
  op_t                     op, iss_op;
  logic                    b_typed, exec_mem, iss, iss_mem, is_binary, div0, acc_ok;
  logic [3:0]              cnt, digit;
  logic [AW-1:0]           acc_next;

  assign key_ready = (state != S_EXEC);
  assign digit     = key_data[3:0];
  assign eff_b     = b_typed ? b : a;

  // Operands are non-negative while being typed, so accumulation is done unsigned with headroom.
  always_comb begin
    acc_next  = (state == S_ENTRY_B ? {5'b0, b} : {5'b0, a}) * AW'(10) + AW'(digit);
    acc_ok    = (digit <= 4'd9) && (acc_next <= VMAX);
    is_binary = (key_data == OP_ADD) || (key_data == OP_SUB) || (key_data == OP_MUL) ||
                (key_data == OP_DIV) || (key_data == OP_MOD);
    div0      = DIV_GUARD && ((op == OP_DIV) || (op == OP_MOD)) && (eff_b == '0);
    iss       = 1'b0;
    iss_mem   = 1'b0;
    iss_op    = key_data;
    iss_a     = a;
    iss_b     = '0;
    if (key_valid && key_ready) begin
      if (key_type == K_OP) begin
        if ((key_data == OP_MADD) || (key_data == OP_MSUB)) begin
          iss     = 1'b1;
          iss_mem = 1'b1;
          iss_a   = disp_value;
          iss_b   = mem_value;
        end else if (key_data == OP_MR) begin
          iss   = 1'b1;
          iss_a = '0;
          iss_b = mem_value;
        end else if (!is_binary && (key_data != OP_MC) && (state != S_ENTRY_B)) begin
          iss = 1'b1;
        end
      end else if ((key_type == K_EQ) && (state == S_ENTRY_B) && !div0) begin
        iss    = 1'b1;
        iss_op = op;
        iss_b  = eff_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_ENTRY_A;
      a          <= '0;
      b          <= '0;
      op         <= '0;
      b_typed    <= 1'b0;
      exec_mem   <= 1'b0;
      cnt        <= '0;
      alu_opcode <= '0;
      alu_num_a  <= '0;
      alu_num_b  <= '0;
      alu_req    <= 1'b0;
      disp_value <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      mem_value  <= '0;
    end else begin
      done <= 1'b0;
      if (state == S_EXEC) begin
        if (cnt == 4'(ALU_LATENCY)) begin
          cnt        <= '0;
          state      <= S_SHOW;
          done       <= 1'b1;
          alu_req    <= 1'b0;
          alu_opcode <= '0;
          alu_num_a  <= '0;
          alu_num_b  <= '0;
          // Memory updates leave the display alone; A follows whatever is shown.
          if (exec_mem) begin
            mem_value <= alu_result;
            a         <= disp_value;
          end else begin
            disp_value <= alu_result;
            a          <= alu_result;
          end
        end else begin
          cnt <= cnt + 4'd1;
        end
      end else if (iss) begin
        state      <= S_EXEC;
        alu_req    <= 1'b1;
        alu_opcode <= iss_op;
        alu_num_a  <= iss_a;
        alu_num_b  <= iss_b;
        exec_mem   <= iss_mem;
      end else if (key_valid) begin
        case (key_type)
          K_DIGIT: begin
            if (state == S_SHOW) begin
              if (digit <= 4'd9) begin
                a          <= RESULT_WIDTH'(digit);
                disp_value <= RESULT_WIDTH'(digit);
                state      <= S_ENTRY_A;
              end
            end else if (acc_ok) begin
              if (state == S_ENTRY_B) begin
                b       <= acc_next[RESULT_WIDTH-1:0];
                b_typed <= 1'b1;
              end else begin
                a <= acc_next[RESULT_WIDTH-1:0];
              end
              disp_value <= acc_next[RESULT_WIDTH-1:0];
            end
          end
          K_OP: begin
            if (key_data == OP_MC) begin
              mem_value <= '0;
            end else if (is_binary) begin
              op <= key_data;
              if (state != S_ENTRY_B) begin
                b       <= '0;
                b_typed <= 1'b0;
              end
              state <= S_ENTRY_B;
            end
          end
          K_EQ: begin
            if ((state == S_ENTRY_B) && div0) begin
              err        <= 1'b1;
              disp_value <= '0;
              a          <= '0;
              done       <= 1'b1;
              state      <= S_SHOW;
            end
          end
          default: begin
            a          <= '0;
            b          <= '0;
            b_typed    <= 1'b0;
            disp_value <= '0;
            err        <= 1'b0;
            state      <= S_ENTRY_A;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_calc_op_sequencer.sv
// tb/tb_calc_op_sequencer.sv - self-checking bench for calc_op_sequencer (latency 0 and 3 instances)
module tb_calc_op_sequencer;
  localparam int MAXV = 2147483647;
`ifdef CALC_SEQ_DIV0_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, key_valid, sel, chk_en;
  logic [1:0] key_type;
  logic [4:0] key_data;
  int lat;

  logic kv0, kv1, rdy0, rdy1, req0, req1, done0, done1, err0, err1;
  logic [4:0] opc0, opc1;
  logic signed [31:0] na0, nb0, na1, nb1, res0, res1, disp0, disp1, mem0, mem1;

  assign kv0 = key_valid & ~sel;
  assign kv1 = key_valid & sel;

  function automatic int alu_fn(input int opc, input int a, input int b);
    longint x, y, r;
    x = a;
    y = b;
    case (opc)
      0:  r = x + y;
      1:  r = x - y;
      2:  r = x * y;
      3:  r = (y == 0) ? -1 : x / y;
      11: r = (y == 0) ? -1 : x % y;
      4:  r = x * x;
      5:  r = -x;
      17: r = x + y;
      18: r = y - x;
      20: r = y;
      default: r = 0;
    endcase
    return int'(r);
  endfunction

  assign res0 = alu_fn(int'(opc0), na0, nb0);
  assign res1 = alu_fn(int'(opc1), na1, nb1);

  calc_op_sequencer #(.OPCODE_LENGTH(5), .RESULT_WIDTH(32), .ALU_LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .key_valid(kv0), .key_ready(rdy0), .key_type(key_type),
    .key_data(key_data), .alu_opcode(opc0), .alu_num_a(na0), .alu_num_b(nb0),
    .alu_req(req0), .alu_result(res0), .disp_value(disp0), .done(done0),
    .err(err0), .mem_value(mem0));

  calc_op_sequencer #(.OPCODE_LENGTH(5), .RESULT_WIDTH(32), .ALU_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .key_valid(kv1), .key_ready(rdy1), .key_type(key_type),
    .key_data(key_data), .alu_opcode(opc1), .alu_num_a(na1), .alu_num_b(nb1),
    .alu_req(req1), .alu_result(res1), .disp_value(disp1), .done(done1),
    .err(err1), .mem_value(mem1));

  logic o_ready, o_req, o_done, o_err;
  logic [4:0] o_opc;
  logic signed [31:0] o_a, o_b, o_disp, o_mem;
  assign o_ready = sel ? rdy1 : rdy0;
  assign o_req   = sel ? req1 : req0;
  assign o_done  = sel ? done1 : done0;
  assign o_err   = sel ? err1 : err0;
  assign o_opc   = sel ? opc1 : opc0;
  assign o_a     = sel ? na1 : na0;
  assign o_b     = sel ? nb1 : nb0;
  assign o_disp  = sel ? disp1 : disp0;
  assign o_mem   = sel ? mem1 : mem0;

  int cmps = 0, fails = 0;
  bit exp_ready, exp_req, exp_done, exp_err;
  int exp_op, exp_a, exp_b, exp_disp, exp_mem;

  // Calculator model: mode 0 = typing A, 1 = typing B, 2 = showing a result.
  int m_st, m_a, m_b, m_op, m_disp, m_mem;
  bit m_typed, m_err;
  bit iss, grd, iss_mem;
  int iss_op, iss_a, iss_b;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    cmps++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("key_ready", o_ready, exp_ready);
      chk("alu_req", o_req, exp_req);
      chk("alu_opcode", o_opc, exp_op);
      chk("alu_num_a", o_a, exp_a);
      chk("alu_num_b", o_b, exp_b);
      chk("disp_value", o_disp, exp_disp);
      chk("done", o_done, exp_done);
      chk("err", o_err, exp_err);
      chk("mem_value", o_mem, exp_mem);
    end
  end

  task automatic exp_reset();
    m_st = 0; m_a = 0; m_b = 0; m_op = 0; m_disp = 0; m_mem = 0; m_typed = 0; m_err = 0;
    exp_ready = 1; exp_req = 0; exp_done = 0; exp_err = 0;
    exp_op = 0; exp_a = 0; exp_b = 0; exp_disp = 0; exp_mem = 0;
  endtask

  task automatic model_key(input int t, input int d);
    longint v;
    int dg;
    iss = 0; grd = 0; iss_mem = 0; iss_op = d; iss_a = m_a; iss_b = 0;
    dg = d & 15;
    case (t)
      0: if (dg <= 9) begin
        if (m_st == 2) begin
          m_a = dg; m_disp = dg; m_st = 0;
        end else if (m_st == 0) begin
          v = longint'(m_a) * 10 + dg;
          if (v <= MAXV) begin m_a = int'(v); m_disp = m_a; end
        end else begin
          v = longint'(m_b) * 10 + dg;
          if (v <= MAXV) begin m_b = int'(v); m_disp = m_b; m_typed = 1; end
        end
      end
      1: begin
        if (d == 17 || d == 18) begin
          iss = 1; iss_mem = 1; iss_a = m_disp; iss_b = m_mem;
        end else if (d == 20) begin
          iss = 1; iss_a = 0; iss_b = m_mem;
        end else if (d == 24) begin
          m_mem = 0;
        end else if (d == 0 || d == 1 || d == 2 || d == 3 || d == 11) begin
          m_op = d;
          if (m_st != 1) begin m_b = 0; m_typed = 0; end
          m_st = 1;
        end else if (m_st != 1) begin
          iss = 1;
        end
      end
      2: if (m_st == 1) begin
        iss_b = m_typed ? m_b : m_a;
        iss_op = m_op;
        if (GUARD && (m_op == 3 || m_op == 11) && iss_b == 0) begin
          grd = 1; m_err = 1; m_disp = 0; m_a = 0; m_st = 2;
        end else begin
          iss = 1;
        end
      end
      default: begin
        m_a = 0; m_b = 0; m_disp = 0; m_err = 0; m_typed = 0; m_st = 0;
      end
    endcase
  endtask

  task automatic model_result();
    int r;
    r = alu_fn(iss_op, iss_a, iss_b);
    if (iss_mem) begin m_mem = r; m_a = m_disp; end
    else begin m_disp = r; m_a = r; end
    m_st = 2;
  endtask

  // Called at posedge+1; returns at posedge+1 with the key fully processed.
  task automatic press(input int t, input int d);
    int n;
    key_type = 2'(t);
    key_data = 5'(d);
    key_valid = 1;
    n = 0;
    while (!o_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!o_ready) begin
      cmps++; fails++;
      $display("FAIL key_ready_timeout: got 0 expected 1 at %0t", $time);
      key_valid = 0;
    end else begin
      @(posedge clk); #1;
      key_valid = 0;
      model_key(t, d);
      if (iss) begin
        for (int i = 0; i <= lat; i++) begin
          exp_ready = 0; exp_req = 1; exp_op = iss_op; exp_a = iss_a; exp_b = iss_b; exp_done = 0;
          @(posedge clk); #1;
        end
        model_result();
        exp_ready = 1; exp_req = 0; exp_op = 0; exp_a = 0; exp_b = 0; exp_done = 1;
      end else begin
        exp_done = grd;
      end
      exp_disp = m_disp; exp_mem = m_mem; exp_err = m_err;
      @(posedge clk); #1;
      exp_done = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int digs[10];
    digs = '{2, 1, 4, 7, 4, 8, 3, 6, 4, 7};
    rst = 1; key_valid = 0; key_type = 0; key_data = 0; sel = 0; chk_en = 0; lat = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    exp_reset();
    chk_en = 1;
    chk("lit_reset_ready", o_ready, 1);
    chk("lit_reset_disp", o_disp, 0);

    press(0, 1); press(0, 2); press(1, 0); press(0, 7); press(2, 0);
    chk("lit_add_19", o_disp, 19);

    press(3, 0); press(0, 5); press(1, 17);
    chk("lit_mplus_5", o_mem, 5);
    press(1, 17);
    chk("lit_mplus_10", o_mem, 10);
    press(3, 0);
    chk("lit_clear_disp", o_disp, 0);
    press(1, 20);
    chk("lit_mr_disp", o_disp, 10);
    chk("lit_mr_mem", o_mem, 10);
    press(1, 24);
    chk("lit_mc_mem", o_mem, 0);

    press(3, 0); press(0, 8); press(1, 3); press(0, 0); press(2, 0);
    chk("lit_div0_err", o_err, GUARD ? 1 : 0);
    chk("lit_div0_disp", o_disp, GUARD ? 0 : -1);
    press(3, 0);
    chk("lit_clear_err", o_err, 0);

    for (int i = 0; i < 10; i++) press(0, digs[i]);
    press(0, 5);
    chk("lit_max_hold", o_disp, MAXV);
    press(0, 12);
    chk("lit_max_d12", o_disp, MAXV);
    press(3, 0); press(0, 12);
    chk("lit_d12_ignored", o_disp, 0);

    press(3, 0); press(0, 6); press(1, 2); press(0, 7); press(2, 0);
    chk("lit_mul_42", o_disp, 42);
    press(2, 0); press(1, 1); press(2, 0);
    chk("lit_chain_self_sub", o_disp, 0);
    press(0, 3); press(1, 5);
    chk("lit_negate", o_disp, -3);
    press(1, 18);
    chk("lit_mminus_mem", o_mem, 3);
    chk("lit_mminus_disp", o_disp, -3);

    press(3, 0); press(0, 9); press(1, 0); press(1, 1); press(0, 4); press(2, 0);
    chk("lit_op_replace", o_disp, 5);

    sel = 1; lat = 3;
    exp_reset();
    press(0, 9); press(1, 4);
    chk("lit_square_81", o_disp, 81);

    // Reset during EXEC, with a digit key presented alongside reset.
    press(3, 0); press(0, 2);
    key_type = 2'd1; key_data = 5'd4; key_valid = 1;
    @(posedge clk); #1;
    model_key(1, 4);
    exp_ready = 0; exp_req = 1; exp_op = iss_op; exp_a = iss_a; exp_b = iss_b;
    key_type = 2'd0; key_data = 5'd5; key_valid = 1; rst = 1;
    @(posedge clk); #1;
    rst = 0; key_valid = 0;
    exp_reset();
    @(posedge clk); #1;
    chk("lit_rst_done", o_done, 0);
    chk("lit_rst_disp", o_disp, 0);
    repeat (4) @(posedge clk);
    #1;
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, fails);
    $finish;
  end
endmodule
